seq_mode_calc: RTL and testbench
================================

// Module: seq_mode_calc
// PURPOSE
//   Burst sequence calculator, parametrised successor of the 4-bit/2-bit-mode lab calculator.
//   - Collects DEPTH unsigned numbers from a serial valid stream.
//   - Applies one of four operations: sort ascending, sort descending, prefix sum or first difference.
//   - Streams back DEPTH signed results, one per cycle.
//   - Sits between the stimulus/pattern interface and downstream checkers in lab-level designs.
// PARAMETERS
//   IN_W   4  width of in_number (unsigned)
//   DEPTH  6  numbers per burst; legal range 2..16
//   OUT_W  IN_W+$clog2(DEPTH)+1  signed result width; derived, do not override
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      in_number/mode qualifier
//   in_number   in   IN_W   unsigned operand
//   mode        in   2      0 sort asc, 1 sort desc, 2 prefix sum, 3 first difference
//   out_valid   out  1      out_result qualifier
//   out_result  out  OUT_W  signed two's-complement result
// BEHAVIOUR
//   Reset: rst_n low clears all state asynchronously, with immediate effect.
//     - FSM goes to IDLE; count=0; out_valid=0; out_result=0; no partial result survives.
//   FSM states: IDLE -> LOAD -> CALC -> OUT -> IDLE.
//   - IDLE: the first in_valid=1 edge does the following, then the FSM goes to LOAD.
//     - Samples mode; mode is ignored on every other cycle.
//     - Stores number 0; sets count=1.
//   - LOAD: each in_valid=1 edge stores the next number and increments count.
//     - in_valid=0 gaps are allowed; state and count are held.
//     - The edge storing number DEPTH-1 moves the FSM to CALC.
//   - CALC: one cycle; precomputes results; in_valid is ignored.
//   - OUT: DEPTH consecutive cycles with out_valid=1, emitting result[0..DEPTH-1] in order.
//     - After the last result: out_valid=0 and the FSM returns to IDLE.
//   Latency: out_valid first rises on the 2nd rising edge after the edge that sampled the last number.
//   in_valid during CALC/OUT is ignored; those numbers are lost and do not start a new burst.
//     - A new burst may begin on the first cycle back in IDLE.
//   out_result is 0 whenever out_valid=0.
//   Sorting: insertion into a sorted register array as each number arrives.
//     - One compare-and-shift per cycle.
//     - Equal values are kept; order among equal values is irrelevant to the output.
//     - Results are zero-extended to OUT_W.
//   Prefix sum: result[i] = a[0]+...+a[i]. OUT_W guarantees no overflow.
//   First difference: result[0] = a[0]; result[i] = a[i]-a[i-1], signed, range -(2^IN_W-1)..2^IN_W-1.
//   A raw (arrival-order) copy is kept for modes 2/3; the sorted copy is kept for modes 0/1.
//   Reset asserted mid-LOAD or mid-OUT: the burst is aborted.
//     - out_valid drops immediately and stays 0 until a fresh full burst completes.
// CONFIGURATION
//   SEQ_CALC_LAST_EN defined: adds output port out_last (1 bit, reset 0).
//     - out_last=1 only on the cycle carrying result[DEPTH-1]; otherwise 0.
//   SEQ_CALC_LAST_EN undefined: port absent; all other behaviour identical.
// TESTING (IN_W=4, DEPTH=6, OUT_W=8, input burst 3,9,1,15,0,9)
//   Mode 0 burst -> out 0,1,3,9,9,15 over 6 cycles; out_valid first rises 2 edges after the last input.
//   Mode 1 burst -> out 15,9,9,3,1,0.
//   Mode 2 burst with in_valid gaps of 1-3 cycles between numbers -> out 3,12,13,28,28,37.
//     - Mode is changed to 0 after the first input; the change is ignored.
//   Mode 3 burst -> out 3,6,-8,14,-15,9 (8'hF8 and 8'hF1 for the negatives).
//     - Random in_valid pulses during OUT are ignored.
//   Six 15s in mode 2 -> last result 90, no overflow. Then a back-to-back burst starting in the first IDLE cycle is accepted correctly.
//   rst_n pulsed low during OUT result[2] -> out_valid/out_result are 0 at once.
//     - The next full burst yields the correct results.
//     - With SEQ_CALC_LAST_EN defined, out_last is high only with result[5].

Source files
------------

// File: rtl/seq_mode_calc_if.sv
// Operand/result stream bundle for seq_mode_calc.
// out_last exists only when SEQ_CALC_LAST_EN is defined.
interface seq_mode_calc_if #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned DEPTH = 6,
    parameter int unsigned OUT_W = IN_W + $clog2(DEPTH) + 1
);
    logic                    in_valid;
    logic [IN_W-1:0]         in_number;
    logic [1:0]              mode;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_result;
`ifdef SEQ_CALC_LAST_EN
    logic                    out_last;
`endif

    // Stimulus side: drives the operand stream, observes results.
    modport master (
        output in_valid, in_number, mode,
`ifdef SEQ_CALC_LAST_EN
        input  out_last,
`endif
        input  out_valid, out_result
    );

    // Calculator side.
    modport slave (
        input  in_valid, in_number, mode,
`ifdef SEQ_CALC_LAST_EN
        output out_last,
`endif
        output out_valid, out_result
    );
endinterface

// File: rtl/seq_mode_calc.sv
// Burst sequence calculator: collects DEPTH numbers, then streams sorted/prefix-sum/difference results.
// Optional feature macro: SEQ_CALC_LAST_EN adds out_last on the final result of a burst.
module seq_mode_calc #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned DEPTH = 6,
    parameter int unsigned OUT_W = IN_W + $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mode_calc_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [IN_W-1:0]   raw_q [DEPTH];
    logic [IN_W-1:0]   raw_d [DEPTH];
    logic [IN_W-1:0]   srt_q [DEPTH];
    logic [IN_W-1:0]   srt_d [DEPTH];
    logic [OUT_W-1:0]  res_q [DEPTH];
    logic [OUT_W-1:0]  res_d [DEPTH];
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_result_q, out_result_d;
    logic              out_last_q, out_last_d;

    logic              accept_c;
    logic [DEPTH-1:0]  gt_c;
    logic [IN_W-1:0]   srt_ins_c [DEPTH];
    logic [OUT_W-1:0]  calc_c    [DEPTH];

    // Insertion step: slots beyond the current count act as +infinity, so the
    // greater-than mask is monotonic and the new value lands at its boundary.
    always_comb begin : insert_comb
        for (int i = 0; i < DEPTH; i++) begin
            gt_c[i] = (CNT_W'(i) >= cnt_q) || (srt_q[i] > bus.in_number);
        end
        srt_ins_c[0] = gt_c[0] ? bus.in_number : srt_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (!gt_c[i]) begin
                srt_ins_c[i] = srt_q[i];
            end else if (gt_c[i-1]) begin
                srt_ins_c[i] = srt_q[i-1];
            end else begin
                srt_ins_c[i] = bus.in_number;
            end
        end
    end

    // Result precompute; prev starts at 0 so result[0] of the difference is a[0].
    always_comb begin : calc_comb
        logic [OUT_W-1:0] acc;
        logic [OUT_W-1:0] prev;
        acc  = '0;
        prev = '0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = acc + OUT_W'(raw_q[i]);
            case (mode_q)
                2'd0:    calc_c[i] = OUT_W'(srt_q[i]);
                2'd1:    calc_c[i] = OUT_W'(srt_q[DEPTH-1-i]);
                2'd2:    calc_c[i] = acc;
                default: calc_c[i] = OUT_W'(raw_q[i]) - prev;
            endcase
            prev = OUT_W'(raw_q[i]);
        end
    end

    // Next-state and registered-output decode.
    always_comb begin : next_comb
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        raw_d        = raw_q;
        srt_d        = srt_q;
        res_d        = res_q;
        out_valid_d  = 1'b0;
        out_result_d = '0;
        out_last_d   = 1'b0;
        accept_c     = bus.in_valid && ((state_q == S_IDLE) || (state_q == S_LOAD));

        if (accept_c) begin
            raw_d[cnt_q] = bus.in_number;
            srt_d        = srt_ins_c;
            cnt_d        = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mode_d  = bus.mode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid && (cnt_q == LAST_IDX)) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d   = calc_c;
                cnt_d   = '0;
                state_d = S_OUT;
            end
            default: begin
                out_valid_d  = 1'b1;
                out_result_d = res_q[cnt_q];
                out_last_d   = (cnt_q == LAST_IDX);
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_last_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                raw_q[i] <= '0;
                srt_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_last_q   <= out_last_d;
            for (int i = 0; i < DEPTH; i++) begin
                raw_q[i] <= raw_d[i];
                srt_q[i] <= srt_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = $signed(out_result_q);
`ifdef SEQ_CALC_LAST_EN
    assign bus.out_last   = out_last_q;
`else
    // Last-beat flag has no port in this build.
    logic unused_last;
    assign unused_last = out_last_q;
`endif

endmodule

// File: tb/tb_seq_mode_calc.sv
// Self-checking bench for seq_mode_calc: directed bursts with literal expectations plus
// random bursts checked against a queue-based reference model.
module tb_seq_mode_calc;
    localparam int unsigned IN_W  = 4;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned OUT_W = IN_W + $clog2(DEPTH) + 1;

    typedef int burst_t [DEPTH];

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    seq_mode_calc_if #(.IN_W(IN_W), .DEPTH(DEPTH)) bus ();

    seq_mode_calc #(.IN_W(IN_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: sort / running sum / neighbour difference on an arrival-order queue.
    task automatic model(input burst_t a, input int m, output burst_t r);
        int q[$];
        int acc;
        acc = 0;
        foreach (a[i]) q.push_back(a[i]);
        case (m)
            0: q.sort();
            1: q.rsort();
            2: foreach (q[i]) begin acc += q[i]; q[i] = acc; end
            default: for (int i = DEPTH - 1; i > 0; i--) q[i] = q[i] - q[i-1];
        endcase
        foreach (r[i]) r[i] = q[i];
    endtask

    task automatic send_burst(input burst_t a, input logic [1:0] m, input logic [1:0] later_mode,
                              input int min_gap, input int max_gap);
        for (int k = 0; k < DEPTH; k++) begin
            int gap;
            gap = (k == 0) ? 0 : int'($urandom_range(max_gap, min_gap));
            for (int g = 0; g < gap; g++) begin
                bus.in_valid  = 1'b0;
                bus.in_number = IN_W'($urandom);
                bus.mode      = 2'($urandom);
                step();
            end
            bus.in_valid  = 1'b1;
            bus.in_number = IN_W'(a[k]);
            bus.mode      = (k == 0) ? m : later_mode;
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input burst_t exp, input bit chk_lat,
                           input bit noise, input bit trail);
        if (chk_lat) begin
            step();
            chk({tag, "_lat1"}, OUT_W'(bus.out_valid), '0);
            step();
            chk({tag, "_lat2"}, OUT_W'(bus.out_valid), OUT_W'(1));
        end else begin
            for (int c = 0; c < 20 && bus.out_valid !== 1'b1; c++) step();
            chk({tag, "_start"}, OUT_W'(bus.out_valid), OUT_W'(1));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                if (noise) begin
                    bus.in_valid  = 1'($urandom);
                    bus.in_number = IN_W'($urandom);
                    bus.mode      = 2'($urandom);
                end
                step();
            end
            chk($sformatf("%s_v%0d", tag, i), OUT_W'(bus.out_valid), OUT_W'(1));
            chk($sformatf("%s_r%0d", tag, i), bus.out_result, OUT_W'(exp[i]));
`ifdef SEQ_CALC_LAST_EN
            chk($sformatf("%s_last%0d", tag, i), OUT_W'(bus.out_last), OUT_W'(i == DEPTH - 1));
`endif
        end
        bus.in_valid = 1'b0;
        if (trail) begin
            step();
            chk({tag, "_end_v"}, OUT_W'(bus.out_valid), '0);
            chk({tag, "_end_r"}, bus.out_result, '0);
        end
    endtask

    initial begin : main
        burst_t demo, fifteens, exp, rnd;
        demo     = '{3, 9, 1, 15, 0, 9};
        fifteens = '{15, 15, 15, 15, 15, 15};

        bus.in_valid  = 1'b0;
        bus.in_number = '0;
        bus.mode      = 2'd0;
        rst_n         = 1'b0;
        #1;
        chk("rst_valid", OUT_W'(bus.out_valid), '0);
        chk("rst_result", bus.out_result, '0);
`ifdef SEQ_CALC_LAST_EN
        chk("rst_last", OUT_W'(bus.out_last), '0);
`endif
        repeat (3) step();
        rst_n = 1'b1;
        step();

        send_burst(demo, 2'd0, 2'd0, 0, 0);
        exp = '{0, 1, 3, 9, 9, 15};
        collect("m0", exp, 1'b1, 1'b0, 1'b1);

        send_burst(demo, 2'd1, 2'd1, 0, 0);
        exp = '{15, 9, 9, 3, 1, 0};
        collect("m1", exp, 1'b1, 1'b0, 1'b1);

        send_burst(demo, 2'd2, 2'd0, 1, 3);
        exp = '{3, 12, 13, 28, 28, 37};
        collect("m2gap", exp, 1'b1, 1'b0, 1'b1);

        send_burst(demo, 2'd3, 2'd3, 0, 0);
        exp = '{3, 6, -8, 14, -15, 9};
        collect("m3noise", exp, 1'b1, 1'b1, 1'b1);

        // Max-value prefix sum, then a burst starting on the first cycle back in IDLE.
        send_burst(fifteens, 2'd2, 2'd2, 0, 0);
        exp = '{15, 30, 45, 60, 75, 90};
        collect("m2max", exp, 1'b1, 1'b0, 1'b0);
        send_burst(demo, 2'd3, 2'd3, 0, 0);
        exp = '{3, 6, -8, 14, -15, 9};
        collect("b2b", exp, 1'b1, 1'b0, 1'b1);

        // Reset while result[2] is on the output.
        send_burst(demo, 2'd0, 2'd0, 0, 0);
        repeat (4) step();
        chk("pre_rst_r2", bus.out_result, OUT_W'(3));
        rst_n = 1'b0;
        #1;
        chk("midout_rst_v", OUT_W'(bus.out_valid), '0);
        chk("midout_rst_r", bus.out_result, '0);
`ifdef SEQ_CALC_LAST_EN
        chk("midout_rst_last", OUT_W'(bus.out_last), '0);
`endif
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("post_rst_v%0d", c), OUT_W'(bus.out_valid), '0);
        end
        send_burst(demo, 2'd2, 2'd2, 0, 0);
        exp = '{3, 12, 13, 28, 28, 37};
        collect("after_rst", exp, 1'b1, 1'b0, 1'b1);

        // Reset mid-LOAD: the partial burst must not leak into the next one.
        for (int k = 0; k < 3; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_number = IN_W'(15);
            bus.mode      = 2'd2;
            step();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        chk("midload_v", OUT_W'(bus.out_valid), '0);
        send_burst(demo, 2'd1, 2'd0, 0, 1);
        exp = '{15, 9, 9, 3, 1, 0};
        collect("after_load_rst", exp, 1'b0, 1'b0, 1'b1);

        for (int b = 0; b < 12; b++) begin
            logic [1:0] m;
            m = 2'($urandom);
            foreach (rnd[i]) rnd[i] = int'($urandom_range(15, 0));
            model(rnd, int'(m), exp);
            send_burst(rnd, m, 2'($urandom), 0, 2);
            collect($sformatf("rnd%0d_m%0d", b, m), exp, 1'b1, 1'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
